seg7_capture: RTL

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// Captures a multiplexed 7-segment display into a hex frame: each digit is
// decoded once its pattern has been stable long enough, and a full frame is committed at once.
module seg7_capture #(
    parameter int N_DIG   = 4,
    parameter int STABLE  = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg,
    input  logic [N_DIG-1:0]     dig_n,
    output logic [4*N_DIG-1:0]   value,
    output logic [N_DIG-1:0]     idle,
    output logic [N_DIG-1:0]     err,
    output logic [N_DIG-1:0]     ambig,
    output logic                 frame_valid,
    output logic                 stale
);

    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    STAB_MAX = 8'(STABLE);
    localparam logic [7:0]    STAB_PRE = 8'(STABLE - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [0:0] {SCAN = 1'b0, COMMIT = 1'b1} state_t;

    // Returns {nibble, idle, err, ambig}; 1100000 is read as 6 since B cannot be told apart.
    function automatic logic [6:0] decode(input logic [6:0] s);
        logic [6:0] d;
        case (s)
            7'b0000001: d = {4'h0, 3'b000};
            7'b1001111: d = {4'h1, 3'b000};
            7'b0010010: d = {4'h2, 3'b000};
            7'b0000110: d = {4'h3, 3'b000};
            7'b1001100: d = {4'h4, 3'b000};
            7'b0100100: d = {4'h5, 3'b000};
            7'b1100000: d = {4'h6, 3'b001};
            7'b0001111: d = {4'h7, 3'b000};
            7'b0000000: d = {4'h8, 3'b000};
            7'b0001100: d = {4'h9, 3'b000};
            7'b0001000: d = {4'hA, 3'b000};
            7'b0110001: d = {4'hC, 3'b000};
            7'b1000010: d = {4'hD, 3'b000};
            7'b0110000: d = {4'hE, 3'b000};
            7'b0111000: d = {4'hF, 3'b000};
            7'b1111110: d = {4'h0, 3'b100};
            default:    d = {4'h0, 3'b010};
        endcase
        return d;
    endfunction

    state_t               state_r, state_next_s;
    logic [N_DIG-1:0]     lows_s;
    logic                 sel_s, same_s, capture_s;
    logic [IW-1:0]        idx_s, prev_idx_r;
    logic [6:0]           prev_seg_r, dec_s;
    logic                 prev_sel_r;
    logic [7:0]           stab_r, stab_next_s;
    logic [N_DIG-1:0]     cap_mask_s, captured_r, captured_next_s;
    logic [4*N_DIG-1:0]   shv_r, shv_next_s, value_r;
    logic [N_DIG-1:0]     shi_r, she_r, sha_r, shi_next_s, she_next_s, sha_next_s;
    logic [N_DIG-1:0]     idle_r, err_r, ambig_r;
    logic                 frame_valid_r, stale_r;
    logic [TW-1:0]        tmo_r, tmo_next_s;

    // Digit selection, stability tracking and capture decision.
    always_comb begin
        lows_s = ~dig_n;
        sel_s  = (lows_s != '0) && ((lows_s & (lows_s - N_DIG'(1))) == '0);
        idx_s  = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (lows_s[i]) begin
                idx_s = IW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
        same_s    = prev_sel_r && (idx_s == prev_idx_r) && (seg == prev_seg_r);
        capture_s = sel_s && same_s && (stab_r == STAB_PRE);
        dec_s     = decode(seg);
        if (!sel_s) begin
            stab_next_s = 8'd0;
        end else if (same_s) begin
            stab_next_s = (stab_r == STAB_MAX) ? stab_r : stab_r + 8'd1;
        end else begin
            stab_next_s = 8'd1;
        end
        cap_mask_s = capture_s ? (N_DIG'(1) << idx_s) : '0;
    end

    // Shadow frame, captured bookkeeping, frame FSM and timeout.
    always_comb begin
        shv_next_s = shv_r;
        shi_next_s = shi_r;
        she_next_s = she_r;
        sha_next_s = sha_r;
        if (capture_s) begin
            shv_next_s[int'(idx_s)*4 +: 4] = dec_s[6:3];
            shi_next_s[idx_s] = dec_s[2];
            she_next_s[idx_s] = dec_s[1];
            sha_next_s[idx_s] = dec_s[0];
        end else begin
            shv_next_s = shv_r;
        end
        state_next_s    = SCAN;
        captured_next_s = captured_r | cap_mask_s;
        case (state_r)
            SCAN: begin
                if (captured_next_s == '1) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = SCAN;
                end
            end
            COMMIT: begin
                state_next_s    = SCAN;
                captured_next_s = cap_mask_s;
            end
            default: state_next_s = SCAN;
        endcase
        if (state_next_s == COMMIT) begin
            tmo_next_s = '0;
        end else if ((state_r == SCAN) && (tmo_r != TMO_MAX)) begin
            tmo_next_s = tmo_r + TW'(1);
        end else begin
            tmo_next_s = tmo_r;
        end
    end

    // State and output registers; outputs load on entry to COMMIT so they line up with frame_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= SCAN;
            prev_sel_r    <= 1'b0;
            prev_idx_r    <= '0;
            prev_seg_r    <= '0;
            stab_r        <= 8'd0;
            captured_r    <= '0;
            shv_r         <= '0;
            shi_r         <= '0;
            she_r         <= '0;
            sha_r         <= '0;
            value_r       <= '0;
            idle_r        <= '0;
            err_r         <= '0;
            ambig_r       <= '0;
            frame_valid_r <= 1'b0;
            stale_r       <= 1'b0;
            tmo_r         <= '0;
        end else begin
            state_r       <= state_next_s;
            prev_sel_r    <= sel_s;
            prev_idx_r    <= idx_s;
            prev_seg_r    <= seg;
            stab_r        <= stab_next_s;
            captured_r    <= captured_next_s;
            shv_r         <= shv_next_s;
            shi_r         <= shi_next_s;
            she_r         <= she_next_s;
            sha_r         <= sha_next_s;
            frame_valid_r <= (state_next_s == COMMIT);
            tmo_r         <= tmo_next_s;
            stale_r       <= (tmo_next_s == TMO_MAX);
            if (state_next_s == COMMIT) begin
                value_r <= shv_next_s;
                idle_r  <= shi_next_s;
                err_r   <= she_next_s;
                ambig_r <= sha_next_s;
            end
        end
    end

    assign value       = value_r;
    assign idle        = idle_r;
    assign err         = err_r;
    assign ambig       = ambig_r;
    assign frame_valid = frame_valid_r;
    assign stale       = stale_r;

endmodule
